// File: rtl/debounce_sync.sv
// Synchronises a raw asynchronous level, qualifies it as stable for STABLE_CYCLES
// samples and emits a clean registered level. Edge pulses enabled by DEBOUNCE_SYNC_EDGE_EN.
module debounce_sync #(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic busy,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // state_q is the bindable view of the FSM for checkers.
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CW'(1);
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge as the FSM.
  always_comb begin
    dout_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      sync_q  <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: stimulus pushes expected dout transitions {level, edge};
// a monitor pops and compares whenever dout changes.
module tb_debounce_sync;

  localparam int LAT = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic dout, busy, rise, fall;

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];

  debounce_sync #(.STABLE_CYCLES(16), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .busy (busy),
    .rise (rise),
    .fall (fall)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic expect_change(input logic lvl, input int unsigned drive_cyc);
    exp_q.push_back({lvl, drive_cyc + LAT});
  endtask

  // monitor / scoreboard
  logic dout_prev = 1'b0;
  always @(negedge clk) begin
    logic changed;
    logic [32:0] exp;
    changed = (dout !== dout_prev);
    if (changed) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dout_change", {31'd0, dout, cyc}, 64'd0);
      end else begin
        exp = exp_q.pop_front();
        check("dout_change_edge", {31'd0, dout, cyc}, {31'd0, exp});
      end
    end
    if (changed || rise || fall) begin
`ifdef DEBOUNCE_SYNC_EDGE_EN
      check("edge_pulses", {62'd0, rise, fall},
            {62'd0, dout & ~dout_prev, ~dout & dout_prev});
`else
      check("edge_pulses_tied", {62'd0, rise, fall}, 64'd0);
`endif
    end
    dout_prev = dout;
  end

  initial begin
    int unsigned c, c2, g, r;

    // reset held, then released with din low for 50 cycles
    step(3);
    #1 check("reset_outputs", {60'd0, dout, busy, rise, fall}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_low_outputs", {60'd0, dout, busy, rise, fall}, 64'd0);
    end

    // clean rise
    c = cyc;
    din = 1'b1;
    expect_change(1'b1, c);
    wait_until(c + 2);
    check("busy_edge2", {63'd0, busy}, 64'd0);
    wait_until(c + 3);
    check("busy_edge3", {63'd0, busy}, 64'd1);
    wait_until(c + 17);
    check("busy_dout_edge17", {62'd0, busy, dout}, 64'h2);
    wait_until(c + 18);
    check("busy_dout_edge18", {62'd0, busy, dout}, 64'h1);
    wait_until(c + 19);
    check("rise_one_cycle", {63'd0, rise}, 64'd0);
    step(5);

    // clean fall
    c = cyc;
    din = 1'b0;
    expect_change(1'b0, c);
    wait_until(c + 17);
    check("fall_busy_edge17", {62'd0, busy, dout}, 64'h3);
    wait_until(c + 25);
    check("fall_settled", {62'd0, busy, dout}, 64'h0);

    // bounce: high 5, low 3, then steady high
    c = cyc;
    din = 1'b1;
    step(5);
    din = 1'b0;
    step(3);
    c2 = cyc;
    din = 1'b1;
    expect_change(1'b1, c2);
    wait_until(c2 + 17);
    check("bounce_no_early_dout", {63'd0, dout}, 64'd0);
    wait_until(c2 + 22);
    check("bounce_settled", {62'd0, busy, dout}, 64'h1);

    // fall with a one-cycle high glitch sampled at edge 10
    c = cyc;
    din = 1'b0;
    wait_until(c + 9);
    din = 1'b1;
    step(1);
    g = cyc;
    din = 1'b0;
    expect_change(1'b0, g);
    wait_until(c + 18);
    check("glitch_dout_held", {63'd0, dout}, 64'd1);
    wait_until(g + 22);
    check("glitch_settled", {62'd0, busy, dout}, 64'h0);

    // reset mid-qualification at cnt=8
    c = cyc;
    din = 1'b1;
    wait_until(c + 10);
    check("busy_before_abort", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    #1 check("async_reset_outputs", {60'd0, dout, busy, rise, fall}, 64'd0);
    step(2);
    r = cyc;
    rst = 1'b1;
    expect_change(1'b1, r);
    wait_until(r + 3);
    check("busy_after_release", {63'd0, busy}, 64'd1);
    wait_until(r + 22);
    check("release_settled", {62'd0, busy, dout}, 64'h1);

    step(2);
    check("expected_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input-conditioning stage that sits directly upstream of the team's asynchronous-reset D flip-flop. It takes a raw, asynchronous, possibly bouncing level such as a push-button or switch, and synchronises it into the clock domain. It then qualifies the level as stable for a programmable number of cycles and produces a clean registered level, which drives the flip-flop's D input. Optional single-cycle edge pulses are available for downstream counters and FSMs.

## Interface
Parameters:
- STABLE_CYCLES, 16, consecutive synchronised samples required before a level change is accepted; legal range ≥ 2
- SYNC_STAGES, 2, depth of the synchroniser flop chain; legal range ≥ 2

Ports:
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset (negedge-sensitive, no synchroniser on rst inside this block)
- din  input  1  raw asynchronous input level
- dout  output  1  debounced, registered level
- busy  output  1  high while a candidate level change is being qualified
- rise  output  1  one-cycle pulse when dout goes 0→1 (see Configuration)
- fall  output  1  one-cycle pulse when dout goes 1→0 (see Configuration)

## Operation
- Synchroniser: SYNC_STAGES-flop shift chain sampling din; its last stage is `s`. All stages reset to 0.
- Counter `cnt`: width $clog2(STABLE_CYCLES), resets to 0.
- FSM, 4 states; reset state is IDLE_LOW:
  - IDLE_LOW (dout=0): if s=1, go to WAIT_HIGH with cnt=1. Otherwise stay.
  - WAIT_HIGH: if s=0, return to IDLE_LOW with cnt=0 (this is a bounce; no output change). Else if cnt=STABLE_CYCLES-1, go to IDLE_HIGH, set dout=1, pulse rise, and clear cnt. Else cnt=cnt+1.
  - IDLE_HIGH (dout=1): if s=0, go to WAIT_LOW with cnt=1.
  - WAIT_LOW: mirror of WAIT_HIGH. On s=1, return to IDLE_HIGH. At terminal count, go to IDLE_LOW, set dout=0, and pulse fall.
- busy=1 exactly in WAIT_HIGH and WAIT_LOW. busy is registered and tracks the state.
- Only an unbroken run of STABLE_CYCLES identical samples of `s` changes dout. Any glitch restarts qualification from zero.
- Reset values: dout=0, busy=0, rise=0, fall=0, cnt=0, all sync stages 0, state IDLE_LOW.
- Reset asserted mid-qualification aborts immediately; no pulse is emitted.
- After reset release with din held high, the full qualification runs and rise fires once.
- The counter never wraps. It is cleared on every state exit, and the terminal compare is an exact equality.

## Timing
- All outputs are registered; there is no combinational path from din to any output.
- Latency: with din changing and then held steady, dout changes on the (SYNC_STAGES + STABLE_CYCLES)th posedge, counting the first edge that samples the new din as edge 1. For defaults this is 18 edges.
- rise and fall are high for exactly the one cycle following the edge on which dout changes. rise and fall are never simultaneously high.
- busy rises SYNC_STAGES+1 edges after din changes, and falls on the same edge that dout changes or the FSM aborts.
- Minimum spacing between consecutive rise/fall pulses is STABLE_CYCLES cycles.

## Configuration
- DEBOUNCE_SYNC_EDGE_EN: when defined, rise and fall are generated as described above.
- When it is undefined:
  - rise and fall are tied constant 0.
  - Their pulse registers are not instantiated.
  - Port list is unchanged.
  - dout and busy behaviour are identical in both builds.

## Test plan
- Reset then release with din=0 for 50 cycles → dout=0, busy=0, rise=fall=0 throughout.
- Defaults, din 0→1 held → busy=1 at edge 3; dout=1 at edge 18; rise=1 for one cycle; busy=0 from the same edge.
- Defaults, din toggles high for 5 cycles, low for 3, then high steadily → the first burst produces no dout change; dout rises 18 edges after the final steady-high transition; exactly one rise.
- dout=1, then din 1→0 held → dout=0 at edge 18 and exactly one fall pulse. Repeat with a 1-cycle high glitch at edge 10 → qualification restarts, and dout falls at 18 edges after the glitch ends.
- Assert rst at cnt=8 while in WAIT_HIGH → all outputs are 0 asynchronously (before the next clk). With din still high after release → rise fires once, 18 edges after release.
- Build without DEBOUNCE_SYNC_EDGE_EN, repeating the second scenario → dout and busy timing are unchanged; rise and fall are stuck at 0.
